// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB register slave with ID, CTRL, ERRCNT and SCRATCH0-4.
// Define APB_SLV_WAIT_EN to make CTRL.WAIT writable and insert wait states.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_regs #(
  parameter logic [`APB_DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B2_0001,
  parameter logic [3:0]                 RESET_WAIT = 4'd0
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       psel,
  input  logic [`PADDR_WIDTH-1:0]    paddr,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [`APB_DATA_WIDTH-1:0] pwdata,
  output logic [`APB_DATA_WIDTH-1:0] prdata,
  output logic                       pready,
  output logic                       pslverr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 wait_cnt;
  logic [2:0]                 idx_q;
  logic                       wr_q;
  logic                       err_q;
  logic [3:0]                 ctrl_wait;
  logic [7:0]                 errcnt;
  logic [`APB_DATA_WIDTH-1:0] scratch [0:4];

  logic                       setup;
  logic [2:0]                 setup_idx;
  logic                       setup_err;
  logic [2:0]                 cur_idx;
  logic                       cur_wr;
  logic                       cur_err;
  logic                       commit;
  logic [`APB_DATA_WIDTH-1:0] rd_data;

  assign setup     = psel && !penable;
  assign setup_idx = paddr[4:2];
  assign setup_err = (paddr[1:0] != 2'b00) || (|paddr[`PADDR_WIDTH-1:5]) ||
                     (pwrite && (setup_idx == 3'd0 || setup_idx == 3'd2));

  // A zero-wait transfer responds straight out of IDLE, so the response path
  // must use the live setup decode there and the captured decode otherwise.
  assign cur_idx = (state_q == IDLE) ? setup_idx : idx_q;
  assign cur_wr  = (state_q == IDLE) ? pwrite    : wr_q;
  assign cur_err = (state_q == IDLE) ? setup_err : err_q;
  assign commit  = (state_q == RESP) && wr_q && !err_q;

  always_comb begin
    rd_data = '0;
    case (cur_idx)
      3'd0:    rd_data = ID_VALUE;
      3'd1:    rd_data = {{(`APB_DATA_WIDTH-4){1'b0}}, ctrl_wait};
      3'd2:    rd_data = {{(`APB_DATA_WIDTH-8){1'b0}}, errcnt};
      3'd3:    rd_data = scratch[0];
      3'd4:    rd_data = scratch[1];
      3'd5:    rd_data = scratch[2];
      3'd6:    rd_data = scratch[3];
      default: rd_data = scratch[4];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (setup) state_d = (ctrl_wait == 4'd0) ? RESP : WAIT;
      WAIT: begin
        if (!psel)                             state_d = IDLE;
        else if (penable && wait_cnt == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= 3'd0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) begin
        wait_cnt <= ctrl_wait;
        idx_q    <= setup_idx;
        wr_q     <= pwrite;
        err_q    <= setup_err;
      end else if (state_q == WAIT && psel && penable) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      pready  <= (state_d == RESP);
      pslverr <= (state_d == RESP) && cur_err;
      prdata  <= (state_d == RESP && !cur_err && !cur_wr) ? rd_data : '0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      errcnt <= 8'd0;
      for (int i = 0; i < 5; i++) scratch[i] <= '0;
    end else begin
      if (state_q == RESP && err_q && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      if (commit) begin
        case (idx_q)
          3'd3:    scratch[0] <= pwdata;
          3'd4:    scratch[1] <= pwdata;
          3'd5:    scratch[2] <= pwdata;
          3'd6:    scratch[3] <= pwdata;
          3'd7:    scratch[4] <= pwdata;
          default: ;
        endcase
      end
    end
  end

`ifdef APB_SLV_WAIT_EN
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                        ctrl_wait <= RESET_WAIT;
    else if (commit && idx_q == 3'd1) ctrl_wait <= pwdata[3:0];
  end
`else
  // Without wait states CTRL.WAIT is hard zero and CTRL writes are dropped.
  logic unused_reset_wait;
  assign unused_reset_wait = ^RESET_WAIT;
  assign ctrl_wait = 4'd0;
`endif

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: directed and randomized APB transfers checked against a
// behavioural register-map model (wait states modelled when APB_SLV_WAIT_EN).
module tb_apb_slave_regs;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_scratch [5];
  logic [3:0]  m_wait;
  logic [7:0]  m_errcnt;
  bit          wait_en;

  always #5 hclk = ~hclk;

  apb_slave_regs dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .psel    (psel),
    .paddr   (paddr),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_scratch[i] = 32'd0;
    m_wait   = 4'd0;
    m_errcnt = 8'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr == 32'h0)      return 32'hA5B2_0001;
    else if (addr == 32'h4) return {28'd0, m_wait};
    else if (addr == 32'h8) return {24'd0, m_errcnt};
    else                    return m_scratch[(addr - 32'hC) / 4];
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge ending the response.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge hclk); #1 penable = 1'b1;
    lat = -1; rdata = 32'd0; err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (pready) begin
        lat = c; rdata = prdata; err = pslverr;
        break;
      end
      checkOutput("wait_prdata", prdata, 32'd0);
      checkOutput("wait_pslverr", {31'd0, pslverr}, 32'd0);
      @(posedge hclk); #1;
    end
    if (lat < 0) checkOutput("timeout_pready", {31'd0, pready}, 32'd1);
    @(posedge hclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    exp_err = (addr[1:0] != 2'b00) || (addr > 32'h1F) || (wr && (addr == 32'h0 || addr == 32'h8));
    exp_lat = wait_en ? int'(m_wait) : 0;
    exp_rd  = (!wr && !exp_err) ? model_read(addr) : 32'd0;
    apb_xfer(wr, addr, wdata, rdata, err, lat);
    checkOutput($sformatf("lat %s %h", wr ? "wr" : "rd", addr), lat, exp_lat);
    checkOutput($sformatf("pslverr %s %h", wr ? "wr" : "rd", addr), {31'd0, err}, {31'd0, exp_err});
    checkOutput($sformatf("prdata %s %h", wr ? "wr" : "rd", addr), rdata, exp_rd);
    if (exp_err) begin
      if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
    end else if (wr) begin
      if (addr == 32'h4) begin
        if (wait_en) m_wait = wdata[3:0];
      end else begin
        m_scratch[(addr - 32'hC) / 4] = wdata;
      end
    end
  endtask

  initial begin
`ifdef APB_SLV_WAIT_EN
    wait_en = 1'b1;
`else
    wait_en = 1'b0;
`endif
    model_reset();
    hreset = 1'b1;
    @(posedge hclk); #1;
    checkOutput("reset_pready", {31'd0, pready}, 32'd0);
    checkOutput("reset_pslverr", {31'd0, pslverr}, 32'd0);
    checkOutput("reset_prdata", prdata, 32'd0);
    @(posedge hclk); #1 hreset = 1'b0;

    applyStimulus(1'b0, 32'h00, 32'd0);
    applyStimulus(1'b1, 32'h0C, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0C, 32'd0);
    applyStimulus(1'b1, 32'h04, 32'hFFFF_FFF3);
    applyStimulus(1'b0, 32'h10, 32'd0);
    applyStimulus(1'b0, 32'h04, 32'd0);
    applyStimulus(1'b1, 32'h04, 32'd0);

    applyStimulus(1'b1, 32'h00, 32'h1234_5678);
    applyStimulus(1'b0, 32'h22, 32'd0);
    applyStimulus(1'b0, 32'h40, 32'd0);
    applyStimulus(1'b0, 32'h00, 32'd0);
    applyStimulus(1'b0, 32'h08, 32'd0);

`ifdef APB_SLV_WAIT_EN
    // Dropping psel mid-wait must abort without a write or an error count.
    applyStimulus(1'b1, 32'h04, 32'd2);
    applyStimulus(1'b1, 32'h18, 32'h1111_2222);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h9999_0000;
    @(posedge hclk); #1 penable = 1'b1;
    @(negedge hclk);
    checkOutput("abort_pready", {31'd0, pready}, 32'd0);
    @(posedge hclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge hclk); #1;
    applyStimulus(1'b0, 32'h18, 32'd0);
    applyStimulus(1'b0, 32'h08, 32'd0);
    applyStimulus(1'b1, 32'h04, 32'd0);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [31:0] addr;
      int          kind;
      kind = $urandom_range(0, 9);
      addr = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      if (kind == 7)      addr = addr | 32'($urandom_range(1, 3));
      else if (kind == 8) addr = addr | (32'd1 << $urandom_range(5, 31));
      else if (kind == 9) addr = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8;
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom);
    end

    for (int n = 0; n < 260; n++) applyStimulus(1'b0, 32'h22, 32'd0);
    applyStimulus(1'b0, 32'h08, 32'd0);

    // Reset asserted during the first access cycle of a pending write.
    applyStimulus(1'b1, 32'h14, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'h04, 32'd2);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h1234_5678;
    @(posedge hclk); #1 penable = 1'b1;
    #1 hreset = 1'b1;
    #1;
    checkOutput("midrst_pready", {31'd0, pready}, 32'd0);
    checkOutput("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    checkOutput("midrst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge hclk); #1 hreset = 1'b0;
    model_reset();
    applyStimulus(1'b0, 32'h14, 32'd0);
    applyStimulus(1'b0, 32'h04, 32'd0);
    applyStimulus(1'b0, 32'h08, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 Parameter ID_VALUE, default 32'hA5B2_0001: value returned by the ID register.
REQ-002 Parameter RESET_WAIT, default 4'd0: reset value of CTRL.WAIT.
REQ-003 hclk  input  1  system clock; all state changes on rising edge.
REQ-004 hreset  input  1  reset; asynchronous, active-high.
REQ-005 psel  input  1  APB select, driven by the bridge psel_en decode.
REQ-006 paddr  input  `PADDR_WIDTH  APB byte address.
REQ-007 penable  input  1  APB enable (access phase).
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 pwdata  input  `APB_DATA_WIDTH  write data.
REQ-010 prdata  output  `APB_DATA_WIDTH  read data, registered.
REQ-011 pready  output  1  transfer complete (pready_x at the bridge), registered.
REQ-012 pslverr  output  1  transfer error (pslverr_x at the bridge), registered.

Function
REQ-013 Register map, word offsets in paddr[4:2]: 0x00 ID (RO), 0x04 CTRL (RW, WAIT in bits [3:0], others read 0), 0x08 ERRCNT (RO, 8-bit in bits [7:0]), 0x0C-0x1C SCRATCH0-4 (RW, 32-bit).
REQ-014 Error on: paddr[1:0] != 0; any paddr bit above bit 4 set; write to ID or ERRCNT.
REQ-015 Error is decoded in the setup cycle from paddr/pwrite and held for the transfer.
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 IDLE: psel=1 and penable=0 loads the wait counter with CTRL.WAIT; WAIT=0 -> RESP, else -> WAIT.
REQ-018 WAIT: counter decrements each cycle with psel=1 and penable=1; counter reaching 1 -> RESP.
REQ-019 RESP: pready=1 for exactly one cycle, then -> IDLE; a back-to-back setup in the next cycle is accepted from IDLE.
REQ-020 Latency: pready rises CTRL.WAIT cycles after the first access cycle (0 = in the first access cycle).
REQ-021 In RESP with no error: read drives prdata with the register value; write commits pwdata at the edge ending RESP.
REQ-022 In RESP with error: pslverr=1, prdata=0, no register changes, ERRCNT increments, saturating at 8'hFF.
REQ-023 prdata, pslverr are 0 whenever pready=0.
REQ-024 psel falling in WAIT (protocol violation): -> IDLE, no write, no pready, ERRCNT unchanged.
REQ-025 A CTRL write takes effect from the next transfer; the current transfer's wait count is unaffected.

Reset
REQ-026 Asserting hreset, including mid-transfer, immediately forces IDLE, pready=0, pslverr=0, prdata=0, wait counter=0.
REQ-027 Reset values: CTRL.WAIT=RESET_WAIT, ERRCNT=0, SCRATCH0-4=0.
REQ-028 After release, the first setup cycle is accepted on the first rising edge with hreset=0.

Configuration
REQ-029 Macro APB_SLV_WAIT_EN defined: CTRL.WAIT is writable and inserts wait states per REQ-017/018.
REQ-030 Macro APB_SLV_WAIT_EN undefined: CTRL.WAIT reads 0, writes to it are ignored without error, the WAIT state is never entered, and every transfer completes in its first access cycle.

Verification
REQ-031 Reset, then read 0x00 -> pready in first access cycle, prdata=32'hA5B2_0001, pslverr=0.
REQ-032 Write 32'hDEAD_BEEF to 0x0C, then read 0x0C -> prdata=32'hDEAD_BEEF, both transfers zero-wait.
REQ-033 With APB_SLV_WAIT_EN: write 3 to 0x04, then read 0x10 -> pready asserted on the 4th access cycle, prdata=0.
REQ-034 Write to 0x00, read 0x22, read 0x40 -> pslverr=1 with pready each time; ID unchanged; ERRCNT reads 3.
REQ-035 Start a write to 0x14 with WAIT=2; assert hreset in the first access cycle -> pready=0 immediately; after release SCRATCH2 reads 0.
